controller_sequencer: RTL
=========================

// Module: controller_sequencer
// PURPOSE
//  SAP-1 control unit. A 6-state ring counter (T1..T6) plus an opcode decoder.
//  Drives the 12-bit control word CON to PC, MAR, RAM, IR, A, ALU, B and OUT.
//  Supports auto-run and single-step modes; a sticky halt is set on HLT.
//  Opcode comes from the IR upper nibble; CON fans out to all W-bus blocks.
// PARAMETERS
//  OP_W      4   opcode width (IR[7:4])
//  CON_W     12  control word width; fixed bit order below
//  T_STATES  6   ring length; only 6 supported
// PORTS
//  CLK_bar   in   1      system clock; all state updates on posedge CLK_bar
//  CLR_bar   in   1      reset, synchronous, active-low
//  opcode    in   OP_W   IR[7:4]; must be stable during T4..T6
//  auto_run  in   1      1 = advance every clock; 0 = single-step
//  step      in   1      step request; debounced, synchronous to CLK_bar
//  con       out  CON_W  {Cp,Ep,Lm_bar,CE_bar,Li_bar,Ei_bar,La_bar,Ea,Su,Eu,Lb_bar,Lo_bar}
//  t_state   out  6      one-hot ring state, bit0=T1 (debug/LEDs)
//  hlt       out  1      sticky halt flag
// BEHAVIOUR
//  Reset (CLR_bar=0 at an edge): t_state<=6'b000001, hlt<=0, step_q<=1.
//   While CLR_bar=0, con is forced to NOP=12'h3E3 combinationally.
//  advance = ~hlt & (auto_run | (step & ~step_q)); step_q<=step every clock.
//   step_q resets to 1, so a step held through reset gives no advance.
//  On advance, t_state rotates left: T6 wraps to T1. Otherwise t_state holds.
//  con is combinational from (t_state, opcode, advance).
//   If advance=0, con=NOP, so a stall never repeats Cp or a load.
//   A T-state therefore executes in exactly the one cycle it advances.
//  Fetch, any opcode: T1=12'h5E3 (Ep,Lm), T2=12'hBE3 (Cp), T3=12'h263 (CE,Li).
//  LDA 4'h0: T4=12'h1A3 (Ei,Lm), T5=12'h2C3 (CE,La), T6=NOP.
//  ADD 4'h1: T4=12'h1A3, T5=12'h2E1 (CE,Lb), T6=12'h3C7 (Eu,La).
//  SUB 4'h2: same as ADD, except T6=12'h3CF (Su,Eu,La).
//  OUT 4'hE: T4=12'h3F2 (Ea,Lo), T5=NOP, T6=NOP.
//  HLT 4'hF: T4 con=NOP. hlt<=1 at the end of that T4 cycle.
//   After that, t_state is frozen at T4 and con=NOP until reset.
//  Undefined opcodes: T4..T6 = NOP; the sequence continues normally.
//  hlt takes priority over auto_run and step. Only CLR_bar clears it.
//  Mid-instruction reset: the next edge returns to T1 regardless of state.
//   No partial load is repeated.
//  auto_run changes take effect on the next edge; state is never lost.
//  Invariants: t_state is always one-hot. At most one bus driver (Ep,CE_bar,Ei_bar,Ea,Eu) is active.
// STRUCTURE
//  sap1_pkg: opcode_e enum (LDA,ADD,SUB,OUT,HLT); CON bit-index localparams;
//   CON_NOP and per-step control word constants; t_state_t typedef (6-bit one-hot).
//   The package is shared with the IR, ALU and the top level.
//  Sub-module ring_counter: one-hot rotate with enable and sync clear.
//  Decoder: a case on t_state/opcode in this module.
// TESTING
//  1. Reset, auto_run=1, opcode=0 for 6 clocks -> con = 5E3,BE3,263,1A3,2C3,3E3; t_state back to 000001.
//  2. opcode=2 (SUB), auto_run=1 -> T5=2E1, T6=3CF. opcode=1 gives T6=3C7. opcode=E gives T4=3F2, then 3E3,3E3.
//  3. opcode=F, auto_run=1 -> hlt=1 after the T4 edge. Over 10 more clocks: t_state=001000, con=3E3. CLR_bar pulse -> T1, hlt=0.
//  4. auto_run=0, step held 1 for 5 clocks -> exactly one advance. Over the other 4 clocks, con=3E3 (no repeated Cp).
//  5. step=1 through reset release -> no advance until step drops and rises again.
//  6. CLR_bar=0 while in T5 -> con=3E3 immediately; next edge t_state=000001. Random opcodes over 1k cycles -> t_state one-hot, at most one bus driver active.

Source files
------------

// File: rtl/sap1_pkg.sv
// SAP-1 shared definitions: opcodes, control-word bit positions, ring states
// and the per-step control words used by the controller-sequencer.
package sap1_pkg;

    // Opcodes as they appear in IR[7:4]
    typedef enum logic [3:0] {
        OP_LDA = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    // Bit positions inside CON = {Cp,Ep,Lm_bar,CE_bar,Li_bar,Ei_bar,La_bar,Ea,Su,Eu,Lb_bar,Lo_bar}
    localparam int CON_CP     = 11;
    localparam int CON_EP     = 10;
    localparam int CON_LM_BAR = 9;
    localparam int CON_CE_BAR = 8;
    localparam int CON_LI_BAR = 7;
    localparam int CON_EI_BAR = 6;
    localparam int CON_LA_BAR = 5;
    localparam int CON_EA     = 4;
    localparam int CON_SU     = 3;
    localparam int CON_EU     = 2;
    localparam int CON_LB_BAR = 1;
    localparam int CON_LO_BAR = 0;

    // Control words: every active-low load/enable deasserted is the idle word
    localparam logic [11:0] CON_NOP    = 12'h3E3;
    localparam logic [11:0] CON_FETCH1 = 12'h5E3;  // Ep, Lm
    localparam logic [11:0] CON_FETCH2 = 12'hBE3;  // Cp
    localparam logic [11:0] CON_FETCH3 = 12'h263;  // CE, Li
    localparam logic [11:0] CON_EI_LM  = 12'h1A3;  // Ei, Lm (operand address)
    localparam logic [11:0] CON_CE_LA  = 12'h2C3;  // CE, La
    localparam logic [11:0] CON_CE_LB  = 12'h2E1;  // CE, Lb
    localparam logic [11:0] CON_ADD_LA = 12'h3C7;  // Eu, La
    localparam logic [11:0] CON_SUB_LA = 12'h3CF;  // Su, Eu, La
    localparam logic [11:0] CON_EA_LO  = 12'h3F2;  // Ea, Lo

    // One-hot ring state, bit0 = T1
    typedef logic [5:0] t_state_t;
    localparam t_state_t T1 = 6'b000001;
    localparam t_state_t T2 = 6'b000010;
    localparam t_state_t T3 = 6'b000100;
    localparam t_state_t T4 = 6'b001000;
    localparam t_state_t T5 = 6'b010000;
    localparam t_state_t T6 = 6'b100000;

    // Number of bus drivers a control word turns on (Ep, CE, Ei, Ea, Eu)
    function automatic int unsigned con_bus_drivers(input logic [11:0] c);
        return int'(c[CON_EP]) + int'(!c[CON_CE_BAR]) + int'(!c[CON_EI_BAR])
             + int'(c[CON_EA]) + int'(c[CON_EU]);
    endfunction

endpackage

// File: rtl/controller_sequencer_ring_counter.sv
// One-hot ring counter: rotates left on enable, T6 wraps to T1, sync clear to T1.
module ring_counter
    import sap1_pkg::*;
#(
    parameter int T_STATES = 6
) (
    input  logic                CLK_bar,
    input  logic                CLR_bar,
    input  logic                en,
    output logic [T_STATES-1:0] t_state
);

    logic [T_STATES-1:0] t_next;

    // Next ring value: rotate left when enabled, otherwise hold
    always_comb begin
        t_next = t_state;
        if (en) begin
            t_next = {t_state[T_STATES-2:0], t_state[T_STATES-1]};
        end
    end

    // Ring register with synchronous active-low clear back to T1
    always_ff @(posedge CLK_bar) begin
        if (!CLR_bar) begin
            t_state <= T_STATES'(1);
        end else begin
            t_state <= t_next;
        end
    end

endmodule

// File: rtl/controller_sequencer.sv
// SAP-1 controller-sequencer: T1..T6 ring, opcode decoder, run/step control
// and sticky halt. CON is driven only in the cycle the ring advances.
module controller_sequencer
    import sap1_pkg::*;
#(
    parameter int OP_W     = 4,
    parameter int CON_W    = 12,
    parameter int T_STATES = 6
) (
    input  logic                CLK_bar,
    input  logic                CLR_bar,
    input  logic [OP_W-1:0]     opcode,
    input  logic                auto_run,
    input  logic                step,
    output logic [CON_W-1:0]    con,
    output logic [T_STATES-1:0] t_state,
    output logic                hlt
);

    logic             step_q;
    logic             advance;
    logic             hlt_set;
    logic             ring_en;
    logic [CON_W-1:0] con_dec;

    // Advance on every clock in auto-run, or on a rising step edge; halt blocks both
    always_comb begin
        advance = !hlt && (auto_run || (step && !step_q));
        hlt_set = advance && (t_state == T4) && (opcode == OP_HLT);
        // HLT freezes the ring at T4 instead of moving on to T5
        ring_en = advance && !hlt_set;
    end

    ring_counter #(
        .T_STATES (T_STATES)
    ) u_ring (
        .CLK_bar (CLK_bar),
        .CLR_bar (CLR_bar),
        .en      (ring_en),
        .t_state (t_state)
    );

    // Step edge detector and sticky halt; step_q resets high so a held step is ignored
    always_ff @(posedge CLK_bar) begin
        if (!CLR_bar) begin
            step_q <= 1'b1;
            hlt    <= 1'b0;
        end else begin
            step_q <= step;
            if (hlt_set) begin
                hlt <= 1'b1;
            end
        end
    end

    // Decode the control word for the current T-state and opcode
    always_comb begin
        con_dec = CON_NOP;
        case (t_state)
            T1: con_dec = CON_FETCH1;
            T2: con_dec = CON_FETCH2;
            T3: con_dec = CON_FETCH3;
            T4: begin
                case (opcode)
                    OP_LDA:  con_dec = CON_EI_LM;
                    OP_ADD:  con_dec = CON_EI_LM;
                    OP_SUB:  con_dec = CON_EI_LM;
                    OP_OUT:  con_dec = CON_EA_LO;
                    default: con_dec = CON_NOP;
                endcase
            end
            T5: begin
                case (opcode)
                    OP_LDA:  con_dec = CON_CE_LA;
                    OP_ADD:  con_dec = CON_CE_LB;
                    OP_SUB:  con_dec = CON_CE_LB;
                    default: con_dec = CON_NOP;
                endcase
            end
            T6: begin
                case (opcode)
                    OP_ADD:  con_dec = CON_ADD_LA;
                    OP_SUB:  con_dec = CON_SUB_LA;
                    default: con_dec = CON_NOP;
                endcase
            end
            default: con_dec = CON_NOP;
        endcase
    end

    // Idle word during reset or stall, so no load or Cp pulse is ever repeated
    always_comb begin
        con = CON_NOP;
        if (CLR_bar && advance) begin
            con = con_dec;
        end
    end

endmodule
